// File: rtl/clock_gen_ctl.sv
// Per-channel divided root enables plus a debug clock-enable FSM (OFF/RUN/STEP/BURST).
// Single clock domain: outputs are enables that qualify downstream flops, never clocks.
module clock_gen_ctl #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DIVW   = 8,
  parameter int unsigned BURSTW = 16,
  parameter int unsigned DBGCW  = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             wr_conf,
  input  logic             wr_clk_sel,
  input  logic [31:0]      cfg_din,
  input  logic             ext_run_en,
  input  logic             step_req,
  output logic [NCH-1:0]   root_en,
  output logic             debug_en,
  output logic             debug_en_n,
  output logic             debug_busy,
  output logic [DBGCW-1:0] debug_cnt
);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBurst = 2'd3
  } dbg_state_e;

  // ---------------------------------------------------------------------------
  // Divider channels
  // ---------------------------------------------------------------------------
  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_d [NCH];
  logic [DIVW-1:0] cnt_q [NCH];
  logic [DIVW-1:0] cnt_d [NCH];

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      root_en[ch] = (cnt_q[ch] == div_q[ch]);
      div_d[ch]   = div_q[ch];
      cnt_d[ch]   = root_en[ch] ? '0 : cnt_q[ch] + DIVW'(1);
      // Index comparison against the loop variable ignores indices >= NCH for free.
      if (wr_conf && (cfg_din[27:24] == 4'(ch))) begin
        div_d[ch] = cfg_din[DIVW-1:0];
        cnt_d[ch] = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (reset) begin
        div_q[ch] <= '0;
        cnt_q[ch] <= '0;
      end else begin
        div_q[ch] <= div_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debug enable FSM
  // ---------------------------------------------------------------------------
  dbg_state_e        state_q, state_d;
  logic [BURSTW-1:0] bcnt_q, bcnt_d;
  logic              step_q, step_d;
  logic              debug_en_q, debug_en_d;
  logic [DBGCW-1:0]  dbg_cnt_q, dbg_cnt_d;

  logic [BURSTW-1:0] burst_len;
  dbg_state_e        sel_mode;

  assign burst_len = cfg_din[16+:BURSTW];
  assign sel_mode  = dbg_state_e'(cfg_din[1:0]);

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    step_d     = step_req;
    debug_en_d = 1'b0;
    dbg_cnt_d  = dbg_cnt_q + DBGCW'(debug_en_q);

    unique case (state_q)
      StOff:  debug_en_d = 1'b0;
      StRun:  debug_en_d = ext_run_en;
      StStep: debug_en_d = step_req & ~step_q;
      StBurst: begin
        // Leave BURST on the edge after the last pulse so busy covers every pulse cycle.
        if (bcnt_q == '0) begin
          state_d = StOff;
        end else if (ext_run_en) begin
          debug_en_d = 1'b1;
          bcnt_d     = bcnt_q - BURSTW'(1);
        end
      end
      default: state_d = StOff;
    endcase

    if (wr_clk_sel) begin
      // A mode write aborts a running burst without emitting a final pulse.
      if (state_q == StBurst) begin
        debug_en_d = 1'b0;
      end
      state_d = sel_mode;
      bcnt_d  = '0;
      if (sel_mode == StBurst) begin
        if (burst_len != '0) begin
          bcnt_d = burst_len;
        end else begin
          state_d = StOff;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= StOff;
      bcnt_q     <= '0;
      step_q     <= 1'b0;
      debug_en_q <= 1'b0;
      dbg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      step_q     <= step_d;
      debug_en_q <= debug_en_d;
      dbg_cnt_q  <= dbg_cnt_d;
    end
  end

  assign debug_en   = debug_en_q;
  assign debug_en_n = ~debug_en_q;
  assign debug_busy = (state_q == StBurst);
  assign debug_cnt  = dbg_cnt_q;

  // Only some cfg_din fields are decoded, depending on the parameters.
  logic unused_cfg;
  assign unused_cfg = ^cfg_din;

endmodule

// File: tb/tb_clock_gen_ctl.sv
// Self-checking bench for clock_gen_ctl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-indexed reference model.
module tb_clock_gen_ctl;

  localparam int NCH    = 4;
  localparam int DIVW   = 8;
  localparam int BURSTW = 16;
  localparam int DBGCW  = 16;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             wr_conf;
  logic             wr_clk_sel;
  logic [31:0]      cfg_din;
  logic             ext_run_en;
  logic             step_req;
  logic [NCH-1:0]   root_en;
  logic             debug_en;
  logic             debug_en_n;
  logic             debug_busy;
  logic [DBGCW-1:0] debug_cnt;

  always #5 clk_in = ~clk_in;

  clock_gen_ctl #(
    .NCH    (NCH),
    .DIVW   (DIVW),
    .BURSTW (BURSTW),
    .DBGCW  (DBGCW)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .wr_conf    (wr_conf),
    .wr_clk_sel (wr_clk_sel),
    .cfg_din    (cfg_din),
    .ext_run_en (ext_run_en),
    .step_req   (step_req),
    .root_en    (root_en),
    .debug_en   (debug_en),
    .debug_en_n (debug_en_n),
    .debug_busy (debug_busy),
    .debug_cnt  (debug_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel is described by the cycle of its last divisor
  // write and that divisor; the debug side by mode, remaining pulses and counters.
  int cyc     = 0;
  bit m_valid = 0;
  int m_div  [NCH];
  int m_wcyc [NCH];
  int m_mode;       // 0 OFF, 1 RUN, 2 STEP, 3 BURST
  int m_rem;
  bit m_step_prev;
  bit m_en;
  int m_cnt;

  task automatic model_step();
    bit en_new;
    int len;
    int ch;
    cyc++;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c]  = 0;
        m_wcyc[c] = cyc;
      end
      m_mode = 0; m_rem = 0; m_step_prev = 0; m_en = 0; m_cnt = 0;
      m_valid = 1;
    end else begin
      case (m_mode)
        0:       en_new = 0;
        1:       en_new = ext_run_en;
        2:       en_new = step_req && !m_step_prev;
        default: en_new = !wr_clk_sel && (m_rem > 0) && ext_run_en;
      endcase
      m_cnt = (m_cnt + int'(m_en)) % (1 << DBGCW);
      if (wr_clk_sel) begin
        len    = int'(cfg_din[31:16]);
        m_mode = int'(cfg_din[1:0]);
        m_rem  = 0;
        if (m_mode == 3) begin
          if (len > 0) m_rem = len;
          else m_mode = 0;
        end
      end else if (m_mode == 3) begin
        if (m_rem == 0) m_mode = 0;
        else if (ext_run_en) m_rem--;
      end
      m_step_prev = step_req;
      m_en        = en_new;
      ch = int'(cfg_din[27:24]);
      if (wr_conf && ch < NCH) begin
        m_div[ch]  = int'(cfg_din[DIVW-1:0]);
        m_wcyc[ch] = cyc;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] exp_root;
    if (!m_valid) return;
    for (int c = 0; c < NCH; c++)
      exp_root[c] = (((cyc - m_wcyc[c]) % (m_div[c] + 1)) == m_div[c]);
    chk("root_en", 32'(root_en), 32'(exp_root));
    chk("debug_en", 32'(debug_en), 32'(m_en));
    chk("debug_en_n", 32'(debug_en_n), 32'(!m_en));
    chk("debug_busy", 32'(debug_busy), 32'(m_mode == 3));
    chk("debug_cnt", 32'(debug_cnt), 32'(m_cnt));
  endtask

  // Inputs set before tick() are sampled on the next rising edge; checks run at the falling edge.
  task automatic tick();
    model_step();
    @(negedge clk_in);
    compare();
  endtask

  task automatic wr_div(input int ch, input int d);
    cfg_din = (32'(ch) << 24) | 32'(d);
    wr_conf = 1'b1;
    tick();
    wr_conf = 1'b0;
    cfg_din = '0;
  endtask

  task automatic wr_sel(input int mode, input int len);
    cfg_din    = (32'(len) << 16) | 32'(mode);
    wr_clk_sel = 1'b1;
    tick();
    wr_clk_sel = 1'b0;
    cfg_din    = '0;
  endtask

  initial begin
    int pulses, gap, guard;
    bit gap_done, done;
    logic [15:0] base;
    logic [11:0] mask, en_mask;
    logic [NCH-1:0] others;

    reset = 1'b1; wr_conf = 1'b0; wr_clk_sel = 1'b0; cfg_din = '0;
    ext_run_en = 1'b0; step_req = 1'b0;
    tick();
    chk("reset_root_en", 32'(root_en), 32'hF);
    chk("reset_debug_en", 32'(debug_en), 32'h0);
    chk("reset_debug_en_n", 32'(debug_en_n), 32'h1);
    chk("reset_debug_cnt", 32'(debug_cnt), 32'h0);
    reset = 1'b0;
    repeat (4) tick();
    chk("idle_root_en", 32'(root_en), 32'hF);

    // Channel 1 divisor 2: high in cycles 2, 5, 8; others always high.
    wr_div(1, 2);
    mask = '0; others = '1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      mask[i] = root_en[1];
      others  = others & (root_en | 4'b0010);
    end
    chk("div2_pattern", 32'(mask[9:0]), 32'h124);
    chk("div2_others", 32'(others), 32'hF);
    wr_div(5, 7);
    repeat (4) tick();

    // STEP: held request yields one pulse; second rising edge another.
    wr_sel(2, 0);
    base = debug_cnt; pulses = 0;
    step_req = 1'b1; repeat (5) begin tick(); pulses += int'(debug_en); end
    step_req = 1'b0; repeat (2) begin tick(); pulses += int'(debug_en); end
    step_req = 1'b1; repeat (3) begin tick(); pulses += int'(debug_en); end
    step_req = 1'b0; repeat (3) begin tick(); pulses += int'(debug_en); end
    chk("step_pulses", 32'(pulses), 32'd2);
    chk("step_cnt_delta", 32'(16'(debug_cnt - base)), 32'd2);

    // BURST 5 with a 3-cycle pause after pulse 3.
    wr_sel(0, 0);
    ext_run_en = 1'b1;
    wr_sel(3, 5);
    base = debug_cnt; pulses = 0; gap = 0; gap_done = 0; done = 0; guard = 0;
    while (!done && guard < 30) begin
      tick(); guard++;
      if (debug_en) begin
        pulses++;
        if (pulses == 3 && !gap_done) begin
          ext_run_en = 1'b0;
          repeat (3) begin
            tick();
            if (debug_en) pulses++; else gap++;
          end
          ext_run_en = 1'b1;
          gap_done = 1;
        end
        if (pulses >= 5) begin
          chk("burst_busy_last", 32'(debug_busy), 32'h1);
          tick();
          chk("burst_busy_fall", 32'(debug_busy), 32'h0);
          done = 1;
        end
      end
    end
    chk("burst_pulses", 32'(pulses), 32'd5);
    chk("burst_gap", 32'(gap), 32'd3);
    chk("burst_cnt_delta", 32'(16'(debug_cnt - base)), 32'd5);

    // BURST 10 aborted by RUN after 4 pulses.
    wr_sel(3, 10);
    pulses = 0; guard = 0;
    while (pulses < 4 && guard < 20) begin
      tick(); guard++;
      pulses += int'(debug_en);
    end
    chk("abort_pulses_seen", 32'(pulses), 32'd4);
    wr_sel(1, 0);
    chk("abort_busy", 32'(debug_busy), 32'h0);
    for (int i = 0; i < 12; i++) begin
      ext_run_en = (i % 3) != 0;
      tick();
    end

    // BURST 0: no pulses.
    ext_run_en = 1'b1;
    wr_sel(0, 0);
    tick();
    wr_sel(3, 0);
    chk("burst0_busy", 32'(debug_busy), 32'h0);
    pulses = int'(debug_en);
    repeat (6) begin tick(); pulses += int'(debug_en); end
    chk("burst0_pulses", 32'(pulses), 32'd0);

    // Reset mid-burst, then simultaneous divisor and mode writes after release.
    wr_sel(3, 8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_en", 32'(debug_en), 32'h0);
    chk("rst_mid_busy", 32'(debug_busy), 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_release_en", 32'(debug_en), 32'h0);
    cfg_din = (32'd2 << 24) | 32'd5;   // channel 2 divisor 5; mode bits 01 = RUN
    wr_conf = 1'b1; wr_clk_sel = 1'b1; ext_run_en = 1'b1;
    tick();
    wr_conf = 1'b0; wr_clk_sel = 1'b0; cfg_din = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      mask[i]    = root_en[2];
      en_mask[i] = debug_en;
    end
    chk("simul_div_pattern", 32'(mask), 32'h820);
    chk("simul_run_en", 32'(en_mask), 32'hFFE);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      ext_run_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) step_req = ~step_req;
      wr_conf    = ($urandom_range(0, 7) == 0);
      wr_clk_sel = ($urandom_range(0, 11) == 0);
      cfg_din    = $urandom;
      if ($urandom_range(0, 1) == 0) cfg_din[7:0] = 8'($urandom_range(0, 9));
      if (wr_clk_sel) cfg_din[31:16] = 16'($urandom_range(0, 12));
      tick();
    end
    reset = 1'b0; wr_conf = 1'b0; wr_clk_sel = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
